// File: rtl/fire_sequencer_if.sv
// Trigger/ammo request bundle and fire/reload status outputs between the
// control source (master) and fire_sequencer (slave).
interface fire_sequencer_if;
    logic       trigger;
    logic       reload_req;
    logic [3:0] mode_selector;
    logic [8:0] ammo_level;
    logic [8:0] fire_rate;
    logic [2:0] burst_len;
    logic       fire;
    logic       loading;
    logic       busy;
    logic       error;
    logic [7:0] shot_count;

    modport master (
        output trigger, reload_req, mode_selector, ammo_level, fire_rate, burst_len,
        input  fire, loading, busy, error, shot_count
    );

    modport slave (
        input  trigger, reload_req, mode_selector, ammo_level, fire_rate, burst_len,
        output fire, loading, busy, error, shot_count
    );
endinterface

// File: rtl/fire_sequencer.sv
// Trigger-to-fire sequencer: spaced single/burst shots, cooldown, timed reload.
// Define FIRE_SEQ_AUTO_RELOAD_EN to enter RELOAD automatically when ammo runs short.
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | waiting for reload_req or a legal trigger
// FIRE     | single cycle, fire pulse out
// COOLDOWN | timer counts down COOLDOWN_CYCLES before the next shot
// RELOAD   | loading high for RELOAD_CYCLES cycles
module fire_sequencer #(
    parameter int unsigned COOLDOWN_CYCLES = 4,
    parameter int unsigned RELOAD_CYCLES   = 16,
    parameter logic [3:0]  ATTACK_MODE     = 4'b0010
) (
    input  logic               clk,
    input  logic               rst,
    fire_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, FIRE, COOLDOWN, RELOAD} state_t;

    localparam logic [7:0] COOL_LOAD   = 8'(COOLDOWN_CYCLES);
    localparam logic [7:0] RELOAD_LOAD = 8'(RELOAD_CYCLES);

    state_t     state, state_next;
    logic [7:0] timer, timer_next;
    logic [2:0] shots, shots_next;
    logic [7:0] count, count_next;
    logic       error_next;
    logic       fire_q, loading_q, busy_q, error_q;
    logic       ammo_ok, mode_ok, timer_tc;

    assign ammo_ok  = (bus.ammo_level != 9'd0) && (bus.ammo_level >= bus.fire_rate);
    assign mode_ok  = (bus.mode_selector == ATTACK_MODE);
    assign timer_tc = (timer <= 8'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= 8'd0;
            shots     <= 3'd0;
            count     <= 8'd0;
            fire_q    <= 1'b0;
            loading_q <= 1'b0;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            shots     <= shots_next;
            count     <= count_next;
            fire_q    <= (state_next == FIRE);
            loading_q <= (state_next == RELOAD);
            busy_q    <= (state_next != IDLE);
            error_q   <= error_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_next = timer;
        shots_next = shots;
        count_next = count;
        error_next = 1'b0;
        case (state)
            IDLE: begin
                if (bus.reload_req) begin
                    state_next = RELOAD;
                    timer_next = RELOAD_LOAD;
                end else if (bus.trigger && mode_ok && ammo_ok) begin
                    state_next = FIRE;
                    shots_next = (bus.burst_len == 3'd0) ? 3'd1 : bus.burst_len;
                end else if (bus.trigger) begin
                    error_next = 1'b1;
                end
            end
            FIRE: begin
                shots_next = shots - 3'd1;
                timer_next = COOL_LOAD;
                state_next = COOLDOWN;
            end
            COOLDOWN: begin
                if (timer_tc) begin
                    timer_next = 8'd0;
                    if ((shots != 3'd0) && mode_ok && ammo_ok) begin
                        state_next = FIRE;
                    end else begin
                        // leftover burst shots are dropped without an error
                        shots_next = 3'd0;
`ifdef FIRE_SEQ_AUTO_RELOAD_EN
                        if (!ammo_ok) begin
                            state_next = RELOAD;
                            timer_next = RELOAD_LOAD;
                        end else begin
                            state_next = IDLE;
                        end
`else
                        state_next = IDLE;
`endif
                    end
                end else begin
                    timer_next = timer - 8'd1;
                end
            end
            RELOAD: begin
                error_next = bus.trigger;
                if (timer_tc) begin
                    timer_next = 8'd0;
                    state_next = IDLE;
                end else begin
                    timer_next = timer - 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if ((state_next == FIRE) && (count != 8'hFF)) begin
            count_next = count + 8'd1;
        end
    end

    assign bus.fire       = fire_q;
    assign bus.loading    = loading_q;
    assign bus.busy       = busy_q;
    assign bus.error      = error_q;
    assign bus.shot_count = count;
endmodule

// File: doc/fire_sequencer.md
# fire_sequencer

Trigger-to-fire sequencer sitting directly upstream of the weapons/ammo-counter stage. Converts a raw trigger request into spaced single-cycle `fire` pulses: single shot or burst, cooldown between shots, and a timed reload window that drives the counter's load strobe. Gates every shot on attack mode and sufficient ammo, and flags illegal trigger attempts.

## Interface
- `COOLDOWN_CYCLES`, 4: idle cycles between consecutive fire pulses; legal range 1..255.
- `RELOAD_CYCLES`, 16: length of the reload window in cycles; legal range 1..255.
- `ATTACK_MODE`, 4'b0010: `mode_selector` encoding that permits firing.

- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `trigger`  in  1  level trigger request; sampled each cycle.
- `reload_req`  in  1  request a reload window.
- `mode_selector`  in  4  current ship mode.
- `ammo_level`  in  9  current ammo count from the ammo counter.
- `fire_rate`  in  9  ammo consumed per shot.
- `burst_len`  in  3  shots per trigger; 0 is treated as 1.
- `fire`  out  1  one-cycle shot pulse to the ammo counter's down input.
- `loading`  out  1  high for the whole reload window; drives the counter's load.
- `busy`  out  1  high in any state other than IDLE.
- `error`  out  1  one-cycle pulse on an illegal trigger.
- `shot_count`  out  8  saturating count of fire pulses since reset.

## Operation
- `ammo_ok` = (`ammo_level` != 0) and (`ammo_level` >= `fire_rate`), 9-bit unsigned compare. `mode_ok` = (`mode_selector` == `ATTACK_MODE`).
- States: IDLE, FIRE, COOLDOWN, RELOAD.
- IDLE: `reload_req` has priority. `reload_req` -> RELOAD. Otherwise, `trigger` with `mode_ok` and `ammo_ok` -> FIRE, latching `burst_len` (0 becomes 1) into an internal shots-remaining counter. Otherwise, `trigger` -> `error` pulse, stay in IDLE.
- FIRE, always one cycle: `fire`=1, decrement shots-remaining, increment `shot_count` (stops at 255), then -> COOLDOWN with the cooldown counter loaded to `COOLDOWN_CYCLES`.
- COOLDOWN: decrement the cooldown counter each cycle. At terminal count:
  - shots-remaining > 0 and `mode_ok` and `ammo_ok` -> FIRE.
  - Otherwise -> IDLE; any remaining burst shots are discarded silently.
- Triggers during FIRE or COOLDOWN are ignored; no error, no queuing.
- RELOAD: `loading`=1 for exactly `RELOAD_CYCLES` cycles, then -> IDLE. A trigger during RELOAD produces an `error` pulse per cycle asserted. `reload_req` is ignored outside IDLE.
- Reset values: state IDLE; `fire`, `loading`, `busy`, `error` = 0; `shot_count` = 0; internal counters = 0.
- Reset mid-burst or mid-reload aborts immediately and asynchronously; no partial pulse is emitted.

## Timing
- All outputs are registered.
- Trigger accepted at edge N -> `fire` high during cycle N+1 (latency 1).
- In a burst, `fire` rising edges are `COOLDOWN_CYCLES`+1 cycles apart.
- `error` appears the cycle after the offending sample.
- `ammo_ok` is re-evaluated at each cooldown terminal count. `COOLDOWN_CYCLES` >= 1 guarantees the counter's decrement is visible before the next check.
- `loading` rises the cycle after `reload_req` is accepted and falls after `RELOAD_CYCLES` cycles.
- Holding `trigger` high re-arms on the first IDLE cycle after a burst.

## Configuration
- `FIRE_SEQ_AUTO_RELOAD_EN` defined: at cooldown terminal count, if `ammo_ok` is false, go to RELOAD instead of IDLE. This applies whether or not shots remain.
- Undefined: always go to IDLE; reload happens only via `reload_req`.

## Test plan
- Reset then idle, `rst` asserted mid-COOLDOWN -> all outputs 0 asynchronously, state IDLE.
- Mode 0010, ammo 100, rate 1, burst 3, `COOLDOWN_CYCLES`=4, one trigger -> 3 `fire` pulses at cycles 1, 6, 11; `shot_count`=3; `busy` falls after the last cooldown.
- Mode 0001, trigger -> `error` pulse one cycle later, no `fire`. Mode 0010, ammo 0, trigger -> `error`, no `fire`.
- Burst 4, ammo 10, rate 5 (counter decrements per shot) -> 2 pulses, then abort to IDLE. With `FIRE_SEQ_AUTO_RELOAD_EN` -> RELOAD, `loading` high for 16 cycles.
- `reload_req` and `trigger` asserted in the same IDLE cycle -> RELOAD wins. A trigger held during the window gives 16 `error` pulses, then a `fire` one cycle after the return to IDLE.
- 260 single shots -> `shot_count` saturates at 255.
